// File: rtl/popcount_seq_ctrl.sv
// -----------------------------------------------------------------------------
// popcount_seq_ctrl
//
// Sequential population counter. A beat carries up to CHUNKS 14-bit chunks.
// The chunks of a captured beat are pushed one per cycle through a single
// shared 14-input popcount. Their counts are summed into a saturating
// accumulator. Beats are chained into one job until a beat flagged "last"
// completes. The job total is then held on out_count until it is consumed.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   reset_n    : asynchronous active-low reset
//   in_valid   : input beat offered
//   in_ready   : beat accepted this cycle (IDLE only, and not before the
//                first clock edge after reset release)
//   in_data    : packed chunks, chunk k = in_data[14k+13:14k]
//   in_len     : valid chunk count, 0 treated as 1, values above CHUNKS clamped
//   in_last    : beat closes the current job
//   out_valid  : job result presented (DONE state)
//   out_ready  : downstream takes the result
//   out_count  : saturated job population count (0 when out_valid=0)
//   busy       : FSM is not IDLE
// -----------------------------------------------------------------------------
module popcount_seq_ctrl #(
  parameter int CHUNKS = 4,
  parameter int ACC_W  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [14*CHUNKS-1:0]  in_data,
  input  logic [2:0]            in_len,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [14*CHUNKS-1:0]  data_q,  data_d;
  logic [2:0]            len_q,   len_d;
  logic [2:0]            idx_q,   idx_d;
  logic                  last_q,  last_d;
  logic [ACC_W-1:0]      acc_q,   acc_d;
  // Held low through reset and for the cycle before the first clock edge
  // after release, so no beat is taken while the block is still settling.
  logic                  armed_q, armed_d;

  logic [13:0]           chunk_sel;
  logic [3:0]            chunk_ones;
  logic [ACC_W:0]        sum_wide;
  logic [ACC_W-1:0]      acc_sat;
  logic [2:0]            len_eff;

  // The one and only popcount datapath; every chunk goes through it.
  function automatic logic [3:0] popcount14(input logic [13:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int b = 0; b < 14; b++) begin
      c = c + {3'b000, v[b]};
    end
    return c;
  endfunction

  // Select the chunk addressed by the running index from the captured beat.
  always_comb begin
    chunk_sel = 14'd0;
    for (int k = 0; k < CHUNKS; k++) begin
      if (idx_q == 3'(k)) begin
        chunk_sel = data_q[14*k +: 14];
      end
    end
  end

  assign chunk_ones = popcount14(chunk_sel);

  // One extra bit catches the carry out; any carry means the true sum is
  // beyond the accumulator range, so pin it at all ones.
  assign sum_wide = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, chunk_ones};
  assign acc_sat  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

  // Normalise the offered length: 0 means one chunk, oversize is clamped.
  always_comb begin
    len_eff = in_len;
    if (in_len == 3'd0) begin
      len_eff = 3'd1;
    end else if ({29'd0, in_len} > CHUNKS) begin
      len_eff = 3'(CHUNKS);
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    len_d     = len_q;
    idx_d     = idx_q;
    last_d    = last_q;
    acc_d     = acc_q;
    armed_d   = 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_count = '0;

    case (state_q)
      IDLE: begin
        in_ready = armed_q;
        if (in_valid && armed_q) begin
          data_d  = in_data;
          len_d   = len_eff;
          last_d  = in_last;
          idx_d   = 3'd0;
          state_d = COUNT;
        end
      end

      COUNT: begin
        acc_d = acc_sat;
        idx_d = idx_q + 3'd1;
        // The index never passes len_q-1, so chunks beyond the captured
        // length are never fed to the adder.
        if (idx_q == len_q - 3'd1) begin
          state_d = last_q ? DONE : IDLE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        out_count = acc_q;
        if (out_ready) begin
          acc_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= 3'd0;
      idx_q   <= 3'd0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Testbench for popcount_seq_ctrl: directed scenarios plus randomized jobs,
// with a reference model feeding an expected-result queue and an independent
// monitor that compares every transferred result.
module tb_popcount_seq_ctrl;

  localparam int CHUNKS = 4;
  localparam int ACC_W  = 10;
  localparam int DW     = 14 * CHUNKS;
  localparam int MAXV   = (1 << ACC_W) - 1;

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic [2:0]        in_len;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_count;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int acc_m  = 0;
  bit bp_en  = 0;

  popcount_seq_ctrl #(.CHUNKS(CHUNKS), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: ones in the first effective-length chunks of a beat.
  function automatic int beat_ones(input logic [DW-1:0] d, input logic [2:0] len);
    int eff;
    int s;
    logic [13:0] c;
    eff = (len == 0) ? 1 : ((int'(len) > CHUNKS) ? CHUNKS : int'(len));
    s = 0;
    for (int k = 0; k < eff; k++) begin
      c = d[14*k +: 14];
      s += $countones(c);
    end
    return s;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got=0 required=1");
    end
  endtask

  // Offer one beat; when use_model is set the reference model is updated and
  // a finished job pushes its expected total into the scoreboard.
  task automatic send_beat(input logic [DW-1:0] d, input logic [2:0] len,
                           input logic last, input bit use_model);
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    in_len   = len;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_len   = 3'($urandom_range(0, 7));
    in_last  = 1'($urandom_range(0, 1));
    if (use_model) begin
      acc_m += beat_ones(d, len);
      if (acc_m > MAXV) acc_m = MAXV;
      if (last) begin
        exp_q.push_back(acc_m);
        acc_m = 0;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d required=0 pending", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Monitor: every accepted result is compared against the scoreboard head.
  always @(negedge clk) begin
    int e;
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got=%0d required=none", out_count);
      end else begin
        e = exp_q.pop_front();
        $display("result out_count=%0d expected=%0d", out_count, e);
        if (int'(out_count) != e) begin
          errors++;
          $display("FAIL result got=%0d required=%0d", out_count, e);
        end
      end
    end
  end

  // Random downstream backpressure for the randomized section.
  always @(posedge clk) begin
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] all1;
    logic [DW-1:0] d;
    int cyc;
    int nb;
    all1 = '1;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_len    = 3'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_count", int'(out_count), 0);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Single full beat: 4 COUNT cycles then 56.
    send_beat(all1, 3'd4, 1'b1, 1);
    chk("count_busy", int'(busy), 1);
    chk("count_in_ready", int'(in_ready), 0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency_len4", cyc, 4);
    chk("done_out_count", int'(out_count), 56);
    @(posedge clk); #1;
    chk("after_xfer_in_ready", int'(in_ready), 1);
    chk("after_xfer_out_valid", int'(out_valid), 0);
    drain();

    // Short beat: chunks past in_len ignored (14 + 1 = 15).
    d = {14'h3FFF, 14'h3FFF, 14'h0001, 14'h3FFF};
    send_beat(d, 3'd2, 1'b1, 1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency_len2", cyc, 2);
    chk("short_beat_count", int'(out_count), 15);
    drain();

    // Three-beat job, ready between beats, total 168.
    for (int b = 0; b < 3; b++) begin
      send_beat(all1, 3'd4, (b == 2), 1);
      if (b < 2) begin
        wait_idle();
        chk("between_beats_in_ready", int'(in_ready), 1);
        chk("between_beats_out_valid", int'(out_valid), 0);
      end
    end
    drain();

    // Hold in DONE with out_ready low; in_valid pulses must be ignored.
    out_ready = 1'b0;
    send_beat(all1, 3'd3, 1'b1, 1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'(i % 2 == 0);
      in_data  = {$urandom, $urandom};
      in_len   = 3'd4;
      in_last  = 1'b1;
      @(posedge clk); #1;
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_count", int'(out_count), 42);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    send_beat({42'd0, 14'h0003}, 3'd1, 1'b1, 1);
    drain();

    // Reset in the second COUNT cycle, then a fresh job of 3.
    wait_ready();
    in_valid = 1'b1;
    in_data  = all1;
    in_len   = 3'd4;
    in_last  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_out_count", int'(out_count), 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_in_ready", int'(in_ready), 1);
    acc_m = 0;
    send_beat({42'd0, 14'h0007}, 3'd1, 1'b1, 1);
    drain();

    // Saturation: 20 full beats (1120 ones) pin at 1023.
    for (int b = 0; b < 20; b++) begin
      send_beat(all1, 3'd4, (b == 19), 1);
    end
    drain();

    // Randomized jobs with random lengths (incl. 0 and oversize) and backpressure.
    bp_en = 1;
    for (int j = 0; j < 40; j++) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        d = {$urandom, $urandom};
        send_beat(d, 3'($urandom_range(0, 7)), (b == nb - 1), 1);
      end
    end
    drain();
    bp_en = 0;
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_idle", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
